// File: rtl/seq_writeback_unit.sv
// seq_writeback_unit
// Buffers results from the load unit and the execute stage in a small
// circular FIFO and retires them one per cycle to the register file.
// It also answers two combinational hazard queries against every
// outstanding write.
//
// Ports
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_load_*  / o_load_ready  load-unit result request (higher priority)
//   i_exec_*  / o_exec_ready  execute-stage result request
//   i_stall                   holds the FIFO head while high
//   i_query_source1/2         registers to check for pending writes
//   o_source1/2_pending       1 when the queried register has a write in flight
//   o_register_file_write,
//   o_destination, o_result   registered register-file write port
module seq_writeback_unit #(
    parameter int unsigned DATA_SIZE  = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_exec_valid,
    input  logic [2:0]           i_exec_destination,
    input  logic [DATA_SIZE-1:0] i_exec_result,
    output logic                 o_exec_ready,
    input  logic                 i_load_valid,
    input  logic [2:0]           i_load_destination,
    input  logic [DATA_SIZE-1:0] i_load_result,
    output logic                 o_load_ready,
    input  logic                 i_stall,
    input  logic [2:0]           i_query_source1,
    input  logic [2:0]           i_query_source2,
    output logic                 o_source1_pending,
    output logic                 o_source2_pending,
    output logic                 o_register_file_write,
    output logic [2:0]           o_destination,
    output logic [DATA_SIZE-1:0] o_result
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    // FIFO storage; contents are only meaningful for occupied slots
    logic [2:0]           dest_mem [FIFO_DEPTH];
    logic [DATA_SIZE-1:0] data_mem [FIFO_DEPTH];

    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 wr_q, wr_d;
    logic [2:0]           dest_q, dest_d;
    logic [DATA_SIZE-1:0] result_q, result_d;

    logic                 full;
    logic                 push_load;
    logic                 push_exec;
    logic                 push;
    logic                 pop;
    logic [2:0]           push_dest;
    logic [DATA_SIZE-1:0] push_data;

    logic                 hit1;
    logic                 hit2;
    logic [PTR_W-1:0]     slot;

    // Readiness, push/pop decisions and next-state computation.
    // Readiness looks only at the current count, so a same-cycle pop
    // never frees a slot for a same-cycle push.
    always_comb begin
        full      = (count_q == CNT_FULL);
        push_load = i_load_valid && !full;
        push_exec = i_exec_valid && !full && !i_load_valid;
        push      = push_load || push_exec;
        push_dest = push_load ? i_load_destination : i_exec_destination;
        push_data = push_load ? i_load_result : i_exec_result;
        pop       = (count_q != '0) && !i_stall;

        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        wr_d      = 1'b0;
        dest_d    = dest_q;
        result_d  = result_q;

        // Power-of-two depth: pointer arithmetic wraps naturally
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            wr_d     = 1'b1;
            dest_d   = dest_mem[rd_ptr_q];
            result_d = data_mem[rd_ptr_q];
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Hazard lookup over occupied slots plus the write currently on the port
    always_comb begin
        hit1 = wr_q && (dest_q == i_query_source1);
        hit2 = wr_q && (dest_q == i_query_source2);
        slot = rd_ptr_q;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            slot = rd_ptr_q + PTR_W'(i);
            if (CNT_W'(i) < count_q) begin
                if (dest_mem[slot] == i_query_source1) begin
                    hit1 = 1'b1;
                end
                if (dest_mem[slot] == i_query_source2) begin
                    hit2 = 1'b1;
                end
            end
        end
    end

    // Control and output registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            wr_q     <= 1'b0;
            dest_q   <= '0;
            result_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            wr_q     <= wr_d;
            dest_q   <= dest_d;
            result_q <= result_d;
        end
    end

    // Storage write; not cleared by reset since count gates validity
    always_ff @(posedge i_clk) begin
        if (push && !i_rst) begin
            dest_mem[wr_ptr_q] <= push_dest;
            data_mem[wr_ptr_q] <= push_data;
        end
    end

    assign o_load_ready          = !full;
    assign o_exec_ready          = !full && !i_load_valid;
    assign o_source1_pending     = hit1;
    assign o_source2_pending     = hit2;
    assign o_register_file_write = wr_q;
    assign o_destination         = dest_q;
    assign o_result              = result_q;

endmodule
